interleaver_pp: RTL and testbench

Parametrised, double-buffered 802.11a block interleaver/deinterleaver for the TX and RX chains.
- Accepts a serial stream of DW-bit samples: hard bits on TX, soft metrics on RX.
- Permutes each OFDM symbol of N_CBPS samples per the 802.11a two-step permutation, or its inverse.
- Ping-pong banks let the next symbol be written while the previous one is read out, so symbols stream back-to-back.
- Sits between convolutional encoder and mapper on TX, and between demapper and Viterbi on RX.

---
 rtl/intlv_pkg.sv | 46 ++++
 rtl/intlv_addr_gen.sv | 51 +++++
 rtl/interleaver_pp.sv | 173 +++++++++++++++++
 tb/tb_interleaver_pp.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/intlv_pkg.sv
// Shared definitions for the 802.11a block interleaver: RATE codes, the
// rate -> (N_CBPS, s) tables and the read-side FSM/mode types.
package intlv_pkg;

  localparam int MAX_NCBPS_DEF = 288;

  localparam logic [3:0] RATE_6  = 4'b1101;
  localparam logic [3:0] RATE_9  = 4'b1111;
  localparam logic [3:0] RATE_12 = 4'b0101;
  localparam logic [3:0] RATE_18 = 4'b0111;
  localparam logic [3:0] RATE_24 = 4'b1001;
  localparam logic [3:0] RATE_36 = 4'b1011;
  localparam logic [3:0] RATE_48 = 4'b0001;
  localparam logic [3:0] RATE_54 = 4'b0011;

  typedef enum logic { MODE_INTLV = 1'b0, MODE_DEINTLV = 1'b1 } mode_e;
  typedef enum logic { RD_IDLE = 1'b0, RD_READ = 1'b1 } rd_state_e;

  function automatic logic rate_valid(input logic [3:0] rate);
    case (rate)
      RATE_6, RATE_9, RATE_12, RATE_18,
      RATE_24, RATE_36, RATE_48, RATE_54: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic [8:0] rate_to_ncbps(input logic [3:0] rate);
    case (rate)
      RATE_6,  RATE_9:  return 9'd48;
      RATE_12, RATE_18: return 9'd96;
      RATE_24, RATE_36: return 9'd192;
      RATE_48, RATE_54: return 9'd288;
      default:          return 9'd0;
    endcase
  endfunction

  // s = max(N_BPSC/2, 1)
  function automatic logic [1:0] rate_to_s(input logic [3:0] rate);
    case (rate)
      RATE_24, RATE_36: return 2'd2;
      RATE_48, RATE_54: return 2'd3;
      default:          return 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/intlv_addr_gen.sv
// Incremental 802.11a permutation address j(k) for k = 0,1,2,...
// Tracks r = k mod 16, c = k div 16, i = (N/16)r + c, plus c mod s and
// r mod s. Since N/16 is a multiple of s, i mod s == c mod s, so
//   j = i - (c mod s) + ((c - r) mod s)
// needs no divider. j holds the address of the current k; a step moves it
// to k+1 on the next edge.
module intlv_addr_gen #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          step,
  input  logic [4:0]    n16,
  input  logic [1:0]    s,
  output logic [AW-1:0] j
);

  logic [AW-1:0] i_q, i_n, c_q, c_n, j_n;
  logic [3:0]    r_q, r_n;
  logic [1:0]    cm_q, cm_n, rm_q, rm_n, d;

  // next (r, c, i) and the permuted address for k+1
  always_comb begin
    r_n  = r_q + 4'd1;
    c_n  = c_q;
    i_n  = i_q + AW'(n16);
    cm_n = cm_q;
    rm_n = (rm_q + 2'd1 == s) ? 2'd0 : rm_q + 2'd1;
    if (r_q == 4'd15) begin
      c_n  = c_q + AW'(1);
      i_n  = c_q + AW'(1);
      cm_n = (cm_q + 2'd1 == s) ? 2'd0 : cm_q + 2'd1;
      rm_n = 2'd0;
    end
    d   = (cm_n >= rm_n) ? cm_n - rm_n : cm_n + s - rm_n;
    j_n = i_n - AW'(cm_n) + AW'(d);
  end

  // position state and registered address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q <= '0; c_q <= '0; r_q <= '0; cm_q <= '0; rm_q <= '0; j <= '0;
    end else if (clr) begin
      i_q <= '0; c_q <= '0; r_q <= '0; cm_q <= '0; rm_q <= '0; j <= '0;
    end else if (step) begin
      i_q <= i_n; c_q <= c_n; r_q <= r_n; cm_q <= cm_n; rm_q <= rm_n; j <= j_n;
    end
  end

endmodule

// File: rtl/interleaver_pp.sv
// Double-buffered 802.11a interleaver/deinterleaver. One bank fills while
// the other drains; interleave scatters on write and reads in order,
// deinterleave writes in order and gathers on read.
module interleaver_pp
  import intlv_pkg::*;
#(
  parameter int DW        = 1,
  parameter int MAX_NCBPS = MAX_NCBPS_DEF
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic          iRateEN,
  input  logic [3:0]    iRate,
  input  logic          iMode,
  input  logic          iEN,
  input  logic [DW-1:0] iData,
  output logic [DW-1:0] oData,
  output logic          oValid,
  output logic          oLast,
  output logic          oRateErr
);

  localparam int AW = $clog2(MAX_NCBPS + 1);
  localparam int IW = AW + 1;

  // bank 1 occupies the upper MAX_NCBPS entries
  function automatic logic [IW-1:0] idx(input logic bank, input logic [AW-1:0] addr);
    return bank ? IW'(addr) + IW'(MAX_NCBPS) : IW'(addr);
  endfunction

  logic [DW-1:0] mem [2*MAX_NCBPS];

  // write side
  logic [AW-1:0] w_n, we_n, wcnt;
  logic [1:0]    w_s, we_s;
  mode_e         w_mode, we_mode;
  logic          wbank, rate_ok, rate_err, wlast, swap;

  // read side
  rd_state_e     rd_state;
  logic [AW-1:0] r_n, rcnt;
  logic [1:0]    r_s;
  mode_e         r_mode;
  logic          rbank, rd, rlast;

  // shared address generator
  logic          gen_clr, gen_step;
  logic [4:0]    gen_n16;
  logic [1:0]    gen_s;
  logic [AW-1:0] gen_j;

  // output pipeline: [0] address registered, [1] data registered
  logic [1:0]    vld_pipe, lst_pipe;
  logic [IW-1:0] raddr_q;

  // effective write config: a strobe honoured at wcnt=0 applies to this sample
  always_comb begin
    rate_ok  = iRateEN && rate_valid(iRate) && (wcnt == '0);
    rate_err = iRateEN && !rate_ok;
    we_n     = rate_ok ? AW'(rate_to_ncbps(iRate)) : w_n;
    we_s     = rate_ok ? rate_to_s(iRate) : w_s;
    we_mode  = rate_ok ? mode_e'(iMode) : w_mode;
    wlast    = (wcnt == we_n - AW'(1));
    swap     = iEN && wlast;
    rd       = (rd_state == RD_READ);
    rlast    = (rcnt == r_n - AW'(1));
  end

  // the one generator serves whichever side carries the permutation;
  // both sides of a stream are expected to share a mode
  always_comb begin
    if (we_mode == MODE_INTLV) begin
      gen_clr  = swap;
      gen_step = iEN && !wlast;
      gen_n16  = 5'(we_n >> 4);
      gen_s    = we_s;
    end else begin
      gen_clr  = swap || (rd && rlast);
      gen_step = rd && !rlast;
      gen_n16  = 5'(r_n >> 4);
      gen_s    = r_s;
    end
  end

  intlv_addr_gen #(.AW(AW)) u_addr_gen (
    .clk   (iClk),
    .rst_n (iRst_n),
    .clr   (gen_clr),
    .step  (gen_step),
    .n16   (gen_n16),
    .s     (gen_s),
    .j     (gen_j)
  );

  // write counter, bank toggle, configuration latch and error pulse
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      w_n      <= AW'(rate_to_ncbps(RATE_6));
      w_s      <= rate_to_s(RATE_6);
      w_mode   <= MODE_INTLV;
      wcnt     <= '0;
      wbank    <= 1'b0;
      oRateErr <= 1'b0;
    end else begin
      w_n      <= we_n;
      w_s      <= we_s;
      w_mode   <= we_mode;
      oRateErr <= rate_err;
      if (iEN) begin
        if (wlast) begin
          wcnt  <= '0;
          wbank <= ~wbank;
        end else begin
          wcnt  <= wcnt + AW'(1);
        end
      end
    end
  end

  // sample store write port
  always_ff @(posedge iClk) begin
    if (iEN) mem[idx(wbank, (we_mode == MODE_INTLV) ? gen_j : wcnt)] <= iData;
  end

  // read FSM: drain a full bank, restarting without a gap on a coincident swap
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      rd_state <= RD_IDLE;
      rcnt     <= '0;
      r_n      <= AW'(rate_to_ncbps(RATE_6));
      r_s      <= rate_to_s(RATE_6);
      r_mode   <= MODE_INTLV;
      rbank    <= 1'b0;
    end else begin
      if (rd_state == RD_IDLE) begin
        if (swap) begin
          rd_state <= RD_READ;
          rcnt     <= '0;
        end
      end else if (rlast) begin
        rcnt     <= '0;
        rd_state <= swap ? RD_READ : RD_IDLE;
      end else begin
        rcnt     <= rcnt + AW'(1);
      end
      if (swap) begin
        r_n    <= we_n;
        r_s    <= we_s;
        r_mode <= we_mode;
        rbank  <= wbank;
      end
    end
  end

  // registered read address, registered memory read, valid/last alignment
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      vld_pipe <= '0;
      lst_pipe <= '0;
      raddr_q  <= '0;
      oData    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], rd};
      lst_pipe <= {lst_pipe[0], rd && rlast};
      raddr_q  <= idx(rbank, (r_mode == MODE_DEINTLV) ? gen_j : rcnt);
      oData    <= vld_pipe[0] ? mem[raddr_q] : '0;
    end
  end

  assign oValid = vld_pipe[1];
  assign oLast  = lst_pipe[1];

endmodule

// File: tb/tb_interleaver_pp.sv
// Scoreboard bench: stimulus pushes expected output words; a monitor forked
// from the same initial block pops and compares whenever oValid is high.
// Instance b deinterleaves instance a's output for the round-trip test.
module tb_interleaver_pp;

  localparam int DW = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          last;
  } exp_t;

  logic          iClk = 1'b0;
  logic          iRst_n = 1'b0;
  logic          a_rate_en = 1'b0, a_mode = 1'b0, a_en = 1'b0;
  logic [3:0]    a_rate = 4'd0;
  logic [DW-1:0] a_din = '0, a_dout;
  logic          a_vld, a_last, a_err;
  logic          b_rate_en = 1'b0, b_mode = 1'b0, b_en;
  logic [3:0]    b_rate = 4'd0;
  logic [DW-1:0] b_dout;
  logic          b_vld, b_last, b_err;
  logic          rt_en = 1'b0;

  assign b_en = a_vld & rt_en;

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  interleaver_pp #(.DW(DW)) dut_a (
    .iClk(iClk), .iRst_n(iRst_n), .iRateEN(a_rate_en), .iRate(a_rate), .iMode(a_mode),
    .iEN(a_en), .iData(a_din), .oData(a_dout), .oValid(a_vld), .oLast(a_last), .oRateErr(a_err)
  );

  interleaver_pp #(.DW(DW)) dut_b (
    .iClk(iClk), .iRst_n(iRst_n), .iRateEN(b_rate_en), .iRate(b_rate), .iMode(b_mode),
    .iEN(b_en), .iData(a_dout), .oData(b_dout), .oValid(b_vld), .oLast(b_last), .oRateErr(b_err)
  );

  exp_t          qa[$], qb[$];
  logic [DW-1:0] stim [864];
  int checks = 0, errors = 0;
  int run_len = 0, last_run = 0, rise_cyc = 0, t_last = 0, b_first = -1, b_last_c = 0;
  bit prev_v = 1'b0;

  // reference permutation, straight from the two-step formula
  function automatic int jmap(int k, int n, int s);
    int r, c, i;
    r = k % 16;
    c = k / 16;
    i = (n / 16) * r + c;
    return s * (i / s) + (i + n - r) % s;
  endfunction

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 864; k++) stim[k] = DW'($urandom);
  endtask

  task automatic fill_onehot(input int pos);
    for (int k = 0; k < 864; k++) stim[k] = '0;
    stim[pos] = DW'(1);
  endtask

  // hand-computed one-hot result: a single 1 at output position pos
  task automatic push_onehot(input int n, input int pos);
    for (int m = 0; m < n; m++) qa.push_back('{d: (m == pos) ? DW'(1) : DW'(0), last: (m == n - 1)});
  endtask

  task automatic push_intlv(input int base, input int n, input int s);
    logic [DW-1:0] o [288];
    for (int k = 0; k < n; k++) o[jmap(k, n, s)] = stim[base + k];
    for (int m = 0; m < n; m++) qa.push_back('{d: o[m], last: (m == n - 1)});
  endtask

  task automatic push_plain_b(input int base, input int n);
    for (int m = 0; m < n; m++) qb.push_back('{d: stim[base + m], last: (m == n - 1)});
  endtask

  // all drive tasks start and end 1 time unit after a rising edge
  task automatic send(input int base, input int lo, input int hi, input bit toggle);
    for (int k = lo; k < hi; k++) begin
      a_en  = 1'b1;
      a_din = stim[base + k];
      @(posedge iClk); #1;
      if (toggle && k != hi - 1) begin
        a_en = 1'b0;
        @(posedge iClk); #1;
      end
    end
    a_en   = 1'b0;
    t_last = cyc;
  endtask

  task automatic cfg_a(input logic [3:0] rate, input logic mode);
    a_rate_en = 1'b1; a_rate = rate; a_mode = mode;
    @(posedge iClk); #1;
    a_rate_en = 1'b0;
  endtask

  task automatic cfg_b(input logic [3:0] rate, input logic mode);
    b_rate_en = 1'b1; b_rate = rate; b_mode = mode;
    @(posedge iClk); #1;
    b_rate_en = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((qa.size() != 0 || qb.size() != 0) && t < 3000) begin
      @(posedge iClk); #1;
      t++;
    end
    chk("drain_left", qa.size() + qb.size(), 0);
    repeat (4) @(posedge iClk);
    #1;
  endtask

  initial begin
    fork
      begin
        exp_t e;
        forever begin
          @(negedge iClk);
          if (iRst_n) begin
            if (a_vld) begin
              if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected: got output %0d with nothing expected (cycle %0d)", a_dout, cyc);
              end else begin
                e = qa.pop_front();
                chk("a_data", int'(a_dout), int'(e.d));
                chk("a_last", int'(a_last), int'(e.last));
              end
              if (!prev_v) rise_cyc = cyc;
              run_len++;
              if (a_last) begin
                last_run = run_len;
                run_len  = 0;
              end
            end else begin
              run_len = 0;
            end
            prev_v = a_vld;
            if (b_vld) begin
              if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected: got output %0d with nothing expected (cycle %0d)", b_dout, cyc);
              end else begin
                e = qb.pop_front();
                chk("b_data", int'(b_dout), int'(e.d));
                chk("b_last", int'(b_last), int'(e.last));
              end
              if (b_first < 0) b_first = cyc;
              b_last_c = cyc;
            end
          end else begin
            prev_v  = 1'b0;
            run_len = 0;
          end
        end
      end
    join_none

    // reset state
    repeat (2) @(posedge iClk);
    #1;
    chk("rst_valid", int'(a_vld), 0);
    chk("rst_data",  int'(a_dout), 0);
    chk("rst_last",  int'(a_last), 0);
    chk("rst_err",   int'(a_err), 0);
    iRst_n = 1'b1;
    @(posedge iClk); #1;

    // reset config 1101/interleave: k=1 -> position 3
    fill_onehot(1);
    push_onehot(48, 3);
    send(0, 0, 48, 1'b0);
    drain();
    chk("t1_run_len", last_run, 48);

    // 0001: k=1 -> position 20
    cfg_a(4'b0001, 1'b0);
    fill_onehot(1);
    push_onehot(288, 20);
    send(0, 0, 288, 1'b0);
    drain();

    // 1001: k=17 -> position 12
    cfg_a(4'b1001, 1'b0);
    fill_onehot(17);
    push_onehot(192, 12);
    send(0, 0, 192, 1'b0);
    drain();

    // 0101 with gapped iEN; first output 2 edges after the last accepted sample
    cfg_a(4'b0101, 1'b0);
    fill_rand();
    push_intlv(0, 96, 1);
    send(0, 0, 96, 1'b1);
    drain();
    chk("t4_latency", rise_cyc - t_last, 2);

    // invalid code, then a strobe mid-symbol: both rejected, N stays 96
    a_rate_en = 1'b1; a_rate = 4'b0000;
    @(posedge iClk); #1;
    a_rate_en = 1'b0;
    chk("err_bad_code", int'(a_err), 1);
    @(posedge iClk); #1;
    chk("err_one_cycle", int'(a_err), 0);
    fill_rand();
    push_intlv(0, 96, 1);
    send(0, 0, 10, 1'b0);
    a_rate_en = 1'b1; a_rate = 4'b1101;
    @(posedge iClk); #1;
    a_rate_en = 1'b0;
    chk("err_busy", int'(a_err), 1);
    send(0, 10, 96, 1'b0);
    drain();
    chk("err_n_kept", last_run, 96);

    // round trip at 0011: a interleaves, b deinterleaves, three symbols back-to-back
    cfg_a(4'b0011, 1'b0);
    cfg_b(4'b0011, 1'b1);
    rt_en = 1'b1;
    fill_rand();
    for (int s = 0; s < 3; s++) begin
      push_intlv(s * 288, 288, 3);
      push_plain_b(s * 288, 288);
    end
    b_first = -1;
    send(0, 0, 864, 1'b0);
    drain();
    chk("rt_no_gap", b_last_c - b_first, 863);
    rt_en = 1'b0;

    // reset during readout with the next symbol partly written
    cfg_a(4'b1101, 1'b0);
    fill_rand();
    push_intlv(0, 48, 1);
    send(0, 0, 48, 1'b0);
    send(48, 0, 10, 1'b0);
    chk("mid_pre_valid", int'(a_vld), 1);
    iRst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(a_vld), 0);
    chk("mid_rst_data",  int'(a_dout), 0);
    chk("mid_rst_last",  int'(a_last), 0);
    chk("mid_rst_err",   int'(a_err), 0);
    qa.delete();
    #1;
    iRst_n = 1'b1;
    @(posedge iClk); #1;
    fill_rand();
    push_intlv(0, 48, 1);
    send(0, 0, 48, 1'b0);
    drain();
    chk("post_rst_run", last_run, 48);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
